// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: free-running line/frame counters with sync, blanking,
// pixel-request and frame-start decode. The pixel source answers one clock after each request.
module vga_timing_ctrl #(
    parameter logic [9:0] H_SYNC   = 10'd96,
    parameter logic [9:0] H_BACK   = 10'd40,
    parameter logic [9:0] H_LEFT   = 10'd8,
    parameter logic [9:0] H_VALID  = 10'd640,
    parameter logic [9:0] H_RIGHT  = 10'd8,
    parameter logic [9:0] H_FRONT  = 10'd8,
    parameter logic [9:0] H_TOTAL  = 10'd800,
    parameter logic [9:0] V_SYNC   = 10'd2,
    parameter logic [9:0] V_BACK   = 10'd25,
    parameter logic [9:0] V_TOP    = 10'd8,
    parameter logic [9:0] V_VALID  = 10'd480,
    parameter logic [9:0] V_BOTTOM = 10'd8,
    parameter logic [9:0] V_FRONT  = 10'd2,
    parameter logic [9:0] V_TOTAL  = 10'd525
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_START = H_SYNC + H_BACK + H_LEFT;
    localparam logic [9:0] V_START = V_SYNC + V_BACK + V_TOP;
    localparam logic [9:0] H_END   = H_START + H_VALID;
    localparam logic [9:0] V_END   = V_START + V_VALID;
    localparam logic [9:0] H_SUM   = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam logic [9:0] V_SUM   = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

    // The porch breakdown must add up to the totals the counters wrap on.
    if (H_SUM != H_TOTAL) begin : g_h_total_chk
        $error("vga_timing_ctrl: horizontal segments do not sum to H_TOTAL");
    end
    if (V_SUM != V_TOTAL) begin : g_v_total_chk
        $error("vga_timing_ctrl: vertical segments do not sum to V_TOTAL");
    end

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       line_end;
    logic       frame_end;
    logic       v_active;
    logic       pix_req;

    always_comb begin
        line_end  = (cnt_h_q == H_TOTAL - 10'd1);
        frame_end = (cnt_v_q == V_TOTAL - 10'd1);
        cnt_h_d   = line_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d   = cnt_v_q;
        if (line_end) begin
            cnt_v_d = frame_end ? 10'd0 : cnt_v_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Everything below is pure decode of the counters, so reset takes effect without a clock.
    always_comb begin
        v_active    = (cnt_v_q >= V_START) && (cnt_v_q < V_END);
        hsync       = (cnt_h_q < H_SYNC);
        vsync       = (cnt_v_q < V_SYNC);
        rgb_valid   = v_active && (cnt_h_q >= H_START) && (cnt_h_q < H_END);
        pix_req     = v_active && (cnt_h_q >= H_START - 10'd1) && (cnt_h_q < H_END - 10'd1);
        frame_start = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
        pix_x       = pix_req ? cnt_h_q - (H_START - 10'd1) : 10'h3FF;
        pix_y       = pix_req ? cnt_v_q - V_START : 10'h3FF;
        rgb         = rgb_valid ? pix_data : 16'h0000;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_SYNC, 10'd96, hsync pulse width (clocks)
- H_BACK, 10'd40, horizontal back porch
- H_LEFT, 10'd8, left border
- H_VALID, 10'd640, active pixels per line
- H_RIGHT, 10'd8, right border
- H_FRONT, 10'd8, horizontal front porch
- H_TOTAL, 10'd800, clocks per line (sum of the six above)
- V_SYNC, 10'd2, vsync pulse width (lines)
- V_BACK, 10'd25, vertical back porch
- V_TOP, 10'd8, top border
- V_VALID, 10'd480, active lines per frame
- V_BOTTOM, 10'd8, bottom border
- V_FRONT, 10'd2, vertical front porch
- V_TOTAL, 10'd525, lines per frame (sum of the six above)

REQ-002 Ports, one per line: name, direction, width, meaning.
- vga_clk, in, 1, VGA pixel clock, 25 MHz; the only clock
- sys_rst_n, in, 1, reset; asynchronous assert, active low
- pix_data, in, 16, RGB565 pixel from the downstream picture generator; valid one cycle after the request
- pix_x, out, 10, requested x coordinate; 10'h3FF when not requesting
- pix_y, out, 10, requested y coordinate; 10'h3FF when not requesting
- hsync, out, 1, horizontal sync; active high
- vsync, out, 1, vertical sync; active high
- rgb_valid, out, 1, display-active window
- rgb, out, 16, RGB565 pixel to the DAC/connector
- frame_start, out, 1, one-cycle pulse at the first clock of each frame

Function
REQ-003 cnt_h (10 bit) SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-004 cnt_v (10 bit) SHALL:
- increment only on the clock where cnt_h==H_TOTAL-1;
- wrap from V_TOTAL-1 to 0 on that same clock;
- otherwise hold.
REQ-005 hsync SHALL be 1 iff cnt_h < H_SYNC; vsync SHALL be 1 iff cnt_v < V_SYNC.
REQ-006 Timing constants:
- H_START = H_SYNC+H_BACK+H_LEFT (144)
- V_START = V_SYNC+V_BACK+V_TOP (35)
REQ-007 rgb_valid SHALL be 1 iff both hold:
- H_START <= cnt_h < H_START+H_VALID
- V_START <= cnt_v < V_START+V_VALID
REQ-008 The internal request signal (pix_req) SHALL be asserted iff both hold:
- H_START-1 <= cnt_h < H_START+H_VALID-1
- cnt_v is in the rgb_valid line range

pix_req therefore leads rgb_valid by exactly one clock, matching the downstream generator's one-cycle registered latency.
REQ-009 While pix_req is asserted:
- pix_x = cnt_h-(H_START-1), range 0..639;
- pix_y = cnt_v-V_START, range 0..479.

Otherwise both SHALL be 10'h3FF. All arithmetic is 10-bit unsigned with no overflow in range.
REQ-010 rgb SHALL equal pix_data when rgb_valid=1, else 16'h0000. This path is combinational: zero added latency from pix_data.
REQ-011 frame_start SHALL be 1 iff cnt_h==0 and cnt_v==0.
REQ-012 hsync, vsync, rgb_valid, pix_x, pix_y and frame_start SHALL be decoded from the registered counters only, with no other state.
REQ-013 Line end and frame end coinciding (cnt_h=799, cnt_v=524) SHALL wrap both counters to 0 on the same edge.

Reset
REQ-014 While sys_rst_n=0, cnt_h and cnt_v SHALL be 0 immediately, without waiting for a clock edge. The resulting outputs are:
- hsync=1, vsync=1
- rgb_valid=0, rgb=16'h0000
- pix_x=pix_y=10'h3FF
- frame_start=1
REQ-015 Reset asserted mid-frame SHALL abandon the frame. After release, counting SHALL restart from cnt_h=0, cnt_v=0, with cnt_h=1 on the first clock edge.

Verification
REQ-016 Release reset, run 800 clocks:
- hsync=1 for exactly clocks 0..95, then 0;
- cnt_v advances to 1 on clock 800.
REQ-017 Run one full frame (420000 clocks):
- vsync high for exactly 1600 clocks;
- frame_start pulses exactly once, 420000 clocks apart.
REQ-018 At line cnt_v=35:
- pix_x=0 at cnt_h=143 and pix_x=639 at cnt_h=782;
- pix_x=3FF at cnt_h=783;
- rgb_valid high for cnt_h 144..783 (640 clocks).
REQ-019 Drive pix_data with a register of {pix_y[5:0],pix_x} as a model of the downstream stage:
- every rgb_valid pixel equals the coordinate requested one clock earlier;
- rgb=0 outside the active window.
REQ-020 Line boundaries:
- lines 34 and 515: pix_y=3FF and rgb_valid=0 throughout;
- line 514: pix_y=479 for the request window.
REQ-021 Assert sys_rst_n=0 asynchronously at cnt_v=200:
- outputs reach the REQ-014 values before the next clock edge;
- after release, frame_start is seen 420000 clocks later.
